pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall sequencer for the 5-stage MIPS pipeline; drives the stall bus that every stage
//  register (IF/ID, ID/EX, ...) obeys. Detects load-use hazards between the ID operands and the
//  EX-stage load. Sequences the iterative divider in EX with start/busy/done and a timeout.
//  Merges the stage stall requests (ID, EX) into a single priority-resolved stall vector.
// PARAMETERS
//  STALL_WD     6   stall bus width (= `StallBus); bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB
//  DIV_TIMEOUT  40  max BUSY cycles before forced abort; counter width = $clog2(DIV_TIMEOUT+1)
// PORTS
//  clk             in   1   core clock
//  resetn          in   1   reset, asynchronous, active-low
//  id_rs           in   5   ID source reg 1 address
//  id_rt           in   5   ID source reg 2 address
//  id_use_rs       in   1   ID instruction reads rs
//  id_use_rt       in   1   ID instruction reads rt
//  ex_is_load      in   1   EX instruction is a load (data_ram_en & ~|data_ram_wen)
//  ex_rf_waddr     in   5   EX destination register
//  stallreq_id     in   1   generic stall request from ID
//  stallreq_ex     in   1   generic stall request from EX
//  ex_div_req      in   1   EX holds a div/divu (valid, not bubble)
//  div_start       out  1   one-cycle start pulse to the divider
//  div_ready       in   1   divider result valid (single-cycle pulse)
//  div_res         in   64  {hi,lo} from divider
//  div_res_valid   out  1   EX may retire the div this cycle
//  div_res_q       out  64  captured {hi,lo}
//  div_err         out  1   timeout abort flag, sticky until next div_start
//  stall           out  6   stall vector to all stage registers (1 = `Stop)
// BEHAVIOUR
//  Reset (resetn=0, async): state=IDLE, cnt=0, div_start=0, div_res_valid=0, div_res_q=0,
//   div_err=0, stall=0. Release is synchronous to the next clk edge.
//  FSM (registered state, Moore outputs except div_start):
//   IDLE: ex_div_req=1 -> div_start=1 (combinational in IDLE), cnt<=0, go BUSY.
//   BUSY: cnt<=cnt+1. div_ready=1 -> div_res_q<=div_res, go DONE. Else cnt==DIV_TIMEOUT
//         -> div_res_q<=0, div_err<=1, go DONE. div_ready wins over a same-cycle timeout.
//   DONE: div_res_valid=1 for exactly one cycle; ex_div_req ignored (same instr); go IDLE.
//   A div arriving the cycle after DONE starts a new sequence from IDLE normally.
//  Load-use: lu = ex_is_load & (ex_rf_waddr!=0) &
//   ((id_use_rs & id_rs==ex_rf_waddr) | (id_use_rt & id_rt==ex_rf_waddr)).
//  Stall priority, combinational from state/inputs, highest first:
//   1. (state==IDLE & ex_div_req) | state==BUSY | stallreq_ex -> 6'b001111 (bubble to MEM)
//   2. lu | stallreq_id -> 6'b000111 (bubble to EX)
//   3. otherwise 6'b000000. DONE never stalls.
//  Each load-use costs exactly one bubble: the load leaves EX next cycle, clearing lu.
//  Register $0 is never a hazard. Stages insert a bubble where stall[i]=1 & stall[i+1]=0.
//  div_err clears on the next div_start. resetn asserted mid-BUSY aborts with no div_res_valid.
//  div_ready outside BUSY is ignored; the divider is never restarted while BUSY.
// STRUCTURE
//  Shared defines in lib/defines.vh: `StallBus, `Stop/`NoStop, STALL_LU=6'b000111,
//   STALL_EX=6'b001111, FSM state encodings (2-bit).
//  No sub-modules: a single FSM, counter and comparator block. The divider stays external.
// TESTING
//  1. lw $2 in EX, addu $3,$2,$4 in ID (use_rs) -> stall=000111 for 1 cycle, then 000000.
//  2. lw $0 in EX, ID reads $0 -> stall stays 000000.
//  3. div in EX, div_ready on 5th BUSY cycle, res=64'h1_0000_0002 -> start pulse 1 cycle;
//     001111 from the request cycle through BUSY; DONE: valid=1, res_q=64'h1_0000_0002.
//  4. div, never ready -> DONE after DIV_TIMEOUT+1 BUSY cycles, div_err=1, res_q=0; the next
//     div_start clears div_err.
//  5. div BUSY with load-use in ID at the same time -> stall=001111 (div wins); after DONE,
//     000111 if the hazard persists.
//  6. resetn low mid-BUSY (async) -> all outputs 0 immediately, state IDLE, no div_res_valid.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared stall encodings and divider FSM states for the hazard controller
package pipe_hazard_ctrl_pkg;
  localparam int STALL_BUS = 6;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic [STALL_BUS-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_BUS-1:0] STALL_LU = 6'b000111;
  localparam logic [STALL_BUS-1:0] STALL_EX = 6'b001111;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} div_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use detection, divider start/busy/done sequencing and stall bus merge
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int STALL_WD = 6,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic                ex_is_load,
  input  logic [4:0]          ex_rf_waddr,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                ex_div_req,
  output logic                div_start,
  input  logic                div_ready,
  input  logic [63:0]         div_res,
  output logic                div_res_valid,
  output logic [63:0]         div_res_q,
  output logic                div_err,
  output logic [STALL_WD-1:0] stall
);
  localparam int CW = $clog2(DIV_TIMEOUT + 1);
  div_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic lu, timeout, div_stall;
  always_comb begin
    lu = ex_is_load & (ex_rf_waddr != 5'd0) &
         ((id_use_rs & (id_rs == ex_rf_waddr)) | (id_use_rt & (id_rt == ex_rf_waddr)));
    timeout = cnt == CW'(DIV_TIMEOUT);
    state_nx = state == S_IDLE ? (ex_div_req ? S_BUSY : S_IDLE) :
               state == S_BUSY ? ((div_ready | timeout) ? S_DONE : S_BUSY) : S_IDLE;
    // outputs are forced low while reset is held so the stages see no stall during abort
    div_start = resetn & (state == S_IDLE) & ex_div_req;
    div_stall = div_start | (state == S_BUSY) | stallreq_ex;
    div_res_valid = state == S_DONE;
    stall = !resetn ? STALL_WD'(STALL_NONE) :
            div_stall ? STALL_WD'(STALL_EX) :
            (lu | stallreq_id) ? STALL_WD'(STALL_LU) : STALL_WD'(STALL_NONE);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt <= '0;
      div_res_q <= '0;
      div_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (div_start) begin
        cnt <= '0;
        div_err <= 1'b0;
      end
      if (state == S_BUSY) begin
        cnt <= cnt + 1'b1;
        if (div_ready) div_res_q <= div_res;
        else if (timeout) begin
          div_res_q <= '0;
          div_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of load-use, divider sequencing, timeout and async reset
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, resetn = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rf_waddr = '0;
  logic id_use_rs = 0, id_use_rt = 0, ex_is_load = 0, stallreq_id = 0, stallreq_ex = 0;
  logic ex_div_req = 0, div_ready = 0;
  logic [63:0] div_res = '0;
  logic div_start, div_res_valid, div_err;
  logic [63:0] div_res_q;
  logic [5:0] stall;
  int n_assert = 0, n_fail = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .resetn(resetn), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_is_load(ex_is_load), .ex_rf_waddr(ex_rf_waddr),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .ex_div_req(ex_div_req),
    .div_start(div_start), .div_ready(div_ready), .div_res(div_res),
    .div_res_valid(div_res_valid), .div_res_q(div_res_q), .div_err(div_err), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    settle();
    chk("rst_stall", stall, 6'b000000);
    chk("rst_valid", div_res_valid, 0);
    chk("rst_resq", div_res_q, 0);
    chk("rst_err", div_err, 0);
    chk("rst_start", div_start, 0);
    nxt(); resetn = 1'b1;
    nxt();
    // test 1: lw $2 in EX, addu $3,$2,$4 in ID
    ex_is_load = 1; ex_rf_waddr = 5'd2; id_rs = 5'd2; id_rt = 5'd4; id_use_rs = 1; id_use_rt = 1;
    settle(); chk("lu_rs", stall, 6'b000111);
    nxt(); ex_is_load = 0; ex_rf_waddr = 5'd3; settle(); chk("lu_gone", stall, 6'b000000);
    nxt(); ex_is_load = 1; ex_rf_waddr = 5'd4; settle(); chk("lu_rt", stall, 6'b000111);
    nxt(); id_use_rt = 0; settle(); chk("lu_rt_unused", stall, 6'b000000);
    nxt(); ex_is_load = 0; ex_rf_waddr = 5'd2; settle(); chk("no_load", stall, 6'b000000);
    // test 2: $0 never hazards
    nxt(); ex_is_load = 1; ex_rf_waddr = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_use_rt = 1;
    settle(); chk("lu_zero", stall, 6'b000000);
    nxt(); ex_is_load = 0; id_use_rs = 0; id_use_rt = 0;
    stallreq_id = 1; settle(); chk("req_id", stall, 6'b000111);
    nxt(); stallreq_ex = 1; settle(); chk("req_both", stall, 6'b001111);
    nxt(); stallreq_id = 0; settle(); chk("req_ex", stall, 6'b001111);
    nxt(); stallreq_ex = 0;
    // stray div_ready in IDLE ignored
    div_ready = 1; div_res = 64'hdead; settle(); chk("idle_rdy_stall", stall, 0);
    nxt(); div_ready = 0; settle(); chk("idle_rdy_resq", div_res_q, 0);
    chk("idle_rdy_valid", div_res_valid, 0);
    // test 3: div completes on 5th BUSY cycle
    nxt(); ex_div_req = 1; settle();
    chk("d3_start", div_start, 1); chk("d3_req_stall", stall, 6'b001111);
    for (int i = 1; i <= 5; i++) begin
      nxt();
      if (i == 5) begin div_ready = 1; div_res = 64'h1_0000_0002; end
      settle(); chk("d3_busy_start", div_start, 0); chk("d3_busy_stall", stall, 6'b001111);
    end
    nxt(); div_ready = 0; settle();
    chk("d3_valid", div_res_valid, 1); chk("d3_resq", div_res_q, 64'h1_0000_0002);
    chk("d3_done_stall", stall, 0); chk("d3_done_start", div_start, 0);
    chk("d3_err", div_err, 0);
    nxt(); ex_div_req = 0; settle();
    chk("d3_valid_off", div_res_valid, 0); chk("d3_hold", div_res_q, 64'h1_0000_0002);
    // test 4: timeout after 41 BUSY cycles
    nxt(); ex_div_req = 1; settle(); chk("d4_start", div_start, 1);
    for (int i = 1; i <= 41; i++) begin
      nxt(); settle();
      chk("d4_busy", stall, 6'b001111);
    end
    chk("d4_err_pre", div_err, 0);
    nxt(); settle();
    chk("d4_valid", div_res_valid, 1); chk("d4_err", div_err, 1);
    chk("d4_resq", div_res_q, 0); chk("d4_done_stall", stall, 0);
    nxt(); settle(); chk("d4_restart", div_start, 1); chk("d4_err_held", div_err, 1);
    nxt(); settle(); chk("d4_err_clr", div_err, 0);
    // test 5: load-use during BUSY, div wins, hazard shows in DONE
    ex_is_load = 1; ex_rf_waddr = 5'd7; id_rs = 5'd7; id_use_rs = 1; settle();
    chk("d5_busy_lu", stall, 6'b001111);
    div_ready = 1; div_res = 64'h55;
    nxt(); div_ready = 0; settle();
    chk("d5_done_lu", stall, 6'b000111); chk("d5_valid", div_res_valid, 1);
    chk("d5_resq", div_res_q, 64'h55);
    nxt(); ex_div_req = 0; ex_is_load = 0; id_use_rs = 0; settle();
    chk("d5_clear", stall, 0);
    // test 6: async reset mid-BUSY
    nxt(); ex_div_req = 1;
    nxt(); nxt(); settle(); chk("d6_busy", stall, 6'b001111);
    #2 resetn = 0; #1;
    chk("d6_rst_stall", stall, 0); chk("d6_rst_start", div_start, 0);
    chk("d6_rst_resq", div_res_q, 0); chk("d6_rst_valid", div_res_valid, 0);
    nxt(); ex_div_req = 0; resetn = 1;
    for (int i = 0; i < 3; i++) begin
      nxt(); settle(); chk("d6_no_valid", div_res_valid, 0); chk("d6_idle", stall, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
